// File: rtl/regwb_arbiter.sv
// Round-robin write-back arbiter (ALU/LSU/MDU) feeding one register-file write port,
// with a destination-register busy scoreboard. Optional bypass outputs: REGWB_FORWARD_EN.
module regwb_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_rd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [31:0]     busy
`ifdef REGWB_FORWARD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  // Handshake: a requester transfers in any cycle where its valid and ready are both 1;
  // ready is a pure function of the valids and the pointer, and is never 1 without valid.

  typedef enum logic [1:0] {
    PTR_ALU = 2'd0,
    PTR_LSU = 2'd1,
    PTR_MDU = 2'd2
  } ptr_e;

  ptr_e            ptr_q, ptr_d;
  logic [2:0]      gnt;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [31:0]     busy_q, busy_d;

  // Pointer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Next pointer: one past the winner, or hold when nobody was granted
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = PTR_LSU;
    end else if (gnt[1]) begin
      ptr_d = PTR_MDU;
    end else if (gnt[2]) begin
      ptr_d = PTR_ALU;
    end
  end

  // Grant outputs: search starts at the pointer and wraps through the other two
  always_comb begin
    gnt = 3'b000;
    if (!rst) begin
      case (ptr_q)
        PTR_LSU: begin
          if (lsu_valid)      gnt = 3'b010;
          else if (mdu_valid) gnt = 3'b100;
          else if (alu_valid) gnt = 3'b001;
        end
        PTR_MDU: begin
          if (mdu_valid)      gnt = 3'b100;
          else if (alu_valid) gnt = 3'b001;
          else if (lsu_valid) gnt = 3'b010;
        end
        default: begin
          if (alu_valid)      gnt = 3'b001;
          else if (lsu_valid) gnt = 3'b010;
          else if (mdu_valid) gnt = 3'b100;
        end
      endcase
    end
  end

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign mdu_ready = gnt[2];
  assign xfer      = |gnt;

  // Grant is one-hot, so an AND-OR mux is sufficient
  always_comb begin
    sel_rd   = ({5{gnt[0]}} & alu_rd)
             | ({5{gnt[1]}} & lsu_rd)
             | ({5{gnt[2]}} & mdu_rd);
    sel_data = ({XLEN{gnt[0]}} & alu_data)
             | ({XLEN{gnt[1]}} & lsu_data)
             | ({XLEN{gnt[2]}} & mdu_data);
  end

  // Writes to x0 are accepted but never reach the register file
  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (xfer) begin
      we_d   = (sel_rd != 5'd0);
      rd_d   = sel_rd;
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  // Gating with rst keeps a transfer caught by reset from reaching the register file
  assign rf_we   = we_q & ~rst;
  assign rf_rd   = rd_q;
  assign rf_data = data_q;

  // Scoreboard: the registered write clears, a reservation sets, set wins on collision
  always_comb begin
    busy_d = busy_q;
    if (rf_we) begin
      busy_d[rf_rd] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != 5'd0)) begin
      busy_d[rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

`ifdef REGWB_FORWARD_EN
  assign fwd_valid = xfer && (sel_rd != 5'd0);
  assign fwd_rd    = sel_rd;
  assign fwd_data  = sel_data;
`endif

endmodule

// File: doc/regwb_arbiter.md
REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, which sets the write-back data width.
REQ-002 SHALL have these ports, one per line, as name  direction  width  meaning:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- alu_valid / alu_rd / alu_data  input  1/5/XLEN  ALU write-back request.
- alu_ready  output  1  ALU request granted.
- lsu_valid / lsu_rd / lsu_data  input  1/5/XLEN  load-unit write-back request.
- lsu_ready  output  1  LSU request granted.
- mdu_valid / mdu_rd / mdu_data  input  1/5/XLEN  mul/div write-back request.
- mdu_ready  output  1  MDU request granted.
- rsv_valid / rsv_rd  input  1/5  issue stage reserves a destination register.
- rf_we / rf_rd / rf_data  output  1/5/XLEN  drive the register-file write port.
- busy  output  32  scoreboard; bit n set means xn has a write pending.

Function
REQ-003 SHALL grant at most one requester per cycle; a transfer happens when the requester's valid and ready are both 1.
REQ-004 SHALL drive each ready combinationally from the valid inputs and the priority pointer; ready SHALL never be 1 while its own valid is 0.
REQ-005 SHALL use round-robin arbitration with a 2-bit pointer p in {0=ALU, 1=LSU, 2=MDU}.
- Search order: p, p+1, p+2 (mod 3).
- After a grant to requester i, p SHALL become (i+1) mod 3.
- With no grant, p SHALL hold.
REQ-006 SHALL register the granted transfer: rf_we, rf_rd and rf_data appear exactly 1 cycle after the handshake, and rf_we is high for exactly 1 cycle per transfer.
REQ-007 SHALL accept a transfer with rd=0 (ready asserted as normal) but SHALL drive rf_we=0 in the following cycle; rf_rd/rf_data are don't-care in that cycle.
REQ-008 SHALL, when no transfer occurred in the previous cycle, drive rf_we=0 and SHALL hold rf_rd and rf_data at their last values.
REQ-009 SHALL, on rsv_valid=1 with rsv_rd!=0, set busy[rsv_rd] at the next clock edge; a reservation of x0 SHALL be ignored.
REQ-010 SHALL clear busy[n] at the clock edge at which the registered write to xn occurs (the cycle rf_we=1 with rf_rd=n).
REQ-011 SHALL give priority to set when a set and a clear target the same bit in the same cycle: that bit SHALL end at 1.
REQ-012 SHALL hold busy[0] at 0 in all cycles.
REQ-013 SHALL accept a transfer whose rd is not marked busy without error; the scoreboard is advisory only.
REQ-014 SHALL not block, drop or duplicate any request: a requester holding valid high SHALL be granted within 3 cycles.

Reset
REQ-015 SHALL, while rst=1 at a clock edge, set p=0, rf_we=0, rf_rd=0, rf_data=0 and busy=0.
REQ-016 SHALL drive all ready outputs to 0 while rst=1.
REQ-017 SHALL discard any transfer in flight when rst asserts mid-operation; it SHALL not be written after reset is released.
REQ-018 SHALL behave as if p=0 in the first cycle after reset.

Configuration
REQ-019 SHALL use macro REGWB_FORWARD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (XLEN). These combinationally mirror the current-cycle granted transfer, with fwd_valid=0 when rd=0, for decode-stage bypass.
- Undefined: these ports are absent and behaviour is otherwise identical.

Verification
REQ-020 SHALL cover: single request ALU rd=5, data=0x1234 at cycle t -> alu_ready=1 at t; rf_we=1, rf_rd=5, rf_data=0x1234 at t+1.
REQ-021 SHALL cover: all three valid continuously from reset, each with a distinct rd -> grants ALU, LSU, MDU, ALU... one per cycle, with rf_we=1 every cycle.
REQ-022 SHALL cover: LSU transfer with rd=0 and data=0xFFFF -> lsu_ready=1 and rf_we=0 the next cycle; busy unchanged.
REQ-023 SHALL cover: rsv rd=7 at t -> busy[7]=1 at t+1; ALU rd=7 transfer at t+2 -> write at t+3 and busy[7]=0 after it; reserve rd=7 again at t+3 -> busy[7] stays 1.
REQ-024 SHALL cover: MDU handshake at t with rst=1 at t+1 -> no rf_we=1 afterwards; busy=0; the first post-reset simultaneous ALU+LSU request grants ALU.
REQ-025 SHALL cover: with REGWB_FORWARD_EN defined, an MDU rd=3, data=0xAB handshake -> fwd_valid=1, fwd_rd=3, fwd_data=0xAB in the same cycle.
